// File: rtl/prefix_pkg.sv
// prefix_pkg: shared constants and elaboration-time helpers for the
// pipelined AND-OR prefix network.
//   SPEED_BK / SPEED_SKLANSKY : structure selection.
//   depth()    : number of prefix levels for a width/structure.
//   boundary() : level count after which pipeline register j sits.
//   stage_at() : inverse of boundary(); 0 when no register sits there.
//   partner()  : lane combined into 'lane' at a given level, -1 = pass.
package prefix_pkg;

    localparam int SPEED_BK       = 1;
    localparam int SPEED_SKLANSKY = 2;

    function automatic int depth(input int width, input int speed);
        return (speed == SPEED_BK) ? 2 * $clog2(width) - 1 : $clog2(width);
    endfunction

    function automatic int boundary(input int j, input int d, input int stages);
        return (stages == 0) ? 0 : (j * d) / stages;
    endfunction

    function automatic int stage_at(input int c, input int d, input int stages);
        for (int j = 1; j <= stages; j++)
            if (boundary(j, d, stages) == c) return j;
        return 0;
    endfunction

    // Sklansky: at level l every lane with bit l set takes the top lane of
    // the lower half of its 2^(l+1) block.
    // Brent-Kung: up-sweep levels build power-of-two spans ending at
    // lanes 2^(l+1)-1 mod 2^(l+1); down-sweep levels (l descending) fill
    // the midpoints. Lanes past the width simply never appear.
    function automatic int partner(input int lane, input int level,
                                   input int width, input int speed);
        int lg, l;
        lg = $clog2(width);
        if (speed == SPEED_BK) begin
            if (level < lg) begin
                l = level;
                if (((lane + 1) % (1 << (l + 1))) == 0)
                    return lane - (1 << l);
            end else begin
                l = 2 * lg - 2 - level;
                if ((((lane + 1) % (1 << (l + 1))) == (1 << l)) &&
                    (lane >= (1 << (l + 1))))
                    return lane - (1 << l);
            end
        end else if (((lane >> level) & 1) == 1) begin
            return ((lane >> (level + 1)) << (level + 1)) + (1 << level) - 1;
        end
        return -1;
    endfunction

endpackage

// File: rtl/prefix_and_or_level.sv
// prefix_and_or_level: one purely combinational prefix level.
//   g_i/p_i : generate/propagate entering the level (WIDTH)
//   g_o/p_o : generate/propagate leaving the level (WIDTH)
// Lanes without a partner at this level pass straight through.
module prefix_and_or_level
    import prefix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SPEED = SPEED_SKLANSKY,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        localparam int J = partner(i, LEVEL, WIDTH, SPEED);
        if (J >= 0) begin : g_node
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
            assign p_o[i] = p_i[i] & p_i[J];
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule

// File: rtl/prefix_and_or_pipe.sv
// prefix_and_or_pipe: pipelined, handshaked AND-OR prefix network with a
// group carry chained across beats of a multi-beat word.
//   clk_i, rst_ni            : clock, async active-low reset
//   clear_i                  : sync flush of pipeline and carry chain
//   in_valid_i/in_ready_o    : input handshake
//   in_first_i               : beat starts a new chained word
//   gi_i, pi_i               : generate / propagate in (WIDTH)
//   out_valid_o/out_ready_i  : output handshake
//   go_o, po_o               : chained generate / propagate out (WIDTH)
module prefix_and_or_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SPEED  = SPEED_SKLANSKY,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_first_i,
    input  logic [WIDTH-1:0] gi_i,
    input  logic [WIDTH-1:0] pi_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] go_o,
    output logic [WIDTH-1:0] po_o
);

    localparam int D  = depth(WIDTH, SPEED);
    localparam int NS = (STAGES > 0) ? STAGES : 1;

    // seen_* [c]: value after c levels as consumed by level c+1 (register
    // output where a stage sits at that boundary, otherwise combinational).
    logic [D-1:0][WIDTH-1:0]  seen_g, seen_p;
    logic [D:1][WIDTH-1:0]    lvl_g, lvl_p;
    logic [NS:1][WIDTH-1:0]   st_g_q, st_p_q, nxt_g, nxt_p;
    logic [NS:1]              vld_pipe, first_pipe, nxt_vld, nxt_first;
    logic [NS+1:1]            acc;
    logic [WIDTH-1:0]         res_g, res_p;
    logic                     res_vld, res_first;
    logic                     cin, pin, fire;
    logic                     chain_g_q, chain_p_q;

    assign seen_g[0] = gi_i;
    assign seen_p[0] = pi_i;

    for (genvar l = 1; l <= D; l++) begin : g_level
        prefix_and_or_level #(
            .WIDTH(WIDTH), .SPEED(SPEED), .LEVEL(l - 1)
        ) u_level (
            .g_i(seen_g[l-1]), .p_i(seen_p[l-1]),
            .g_o(lvl_g[l]),    .p_o(lvl_p[l])
        );
        if (l < D) begin : g_tap
            localparam int S = stage_at(l, D, STAGES);
            if (S != 0) begin : g_reg
                assign seen_g[l] = st_g_q[S];
                assign seen_p[l] = st_p_q[S];
            end else begin : g_comb
                assign seen_g[l] = lvl_g[l];
                assign seen_p[l] = lvl_p[l];
            end
        end
    end

    if (STAGES > 0) begin : g_pipe
        for (genvar k = 1; k <= STAGES; k++) begin : g_stage
            localparam int B = boundary(k, D, STAGES);
            assign nxt_g[k] = lvl_g[B];
            assign nxt_p[k] = lvl_p[B];
            if (k == 1) begin : g_head
                assign nxt_vld[k]   = in_valid_i;
                assign nxt_first[k] = in_first_i;
            end else begin : g_body
                assign nxt_vld[k]   = vld_pipe[k-1];
                assign nxt_first[k] = first_pipe[k-1];
            end
        end
        assign res_g     = st_g_q[STAGES];
        assign res_p     = st_p_q[STAGES];
        assign res_vld   = vld_pipe[STAGES];
        assign res_first = first_pipe[STAGES];
    end else begin : g_nopipe
        assign nxt_g     = '0;
        assign nxt_p     = '0;
        assign nxt_vld   = '0;
        assign nxt_first = '0;
        assign res_g     = lvl_g[D];
        assign res_p     = lvl_p[D];
        assign res_vld   = in_valid_i;
        assign res_first = in_first_i;
    end

    // A stage accepts when empty or when the stage after it accepts.
    always_comb begin
        acc       = '0;
        acc[NS+1] = out_ready_i;
        for (int k = NS; k >= 1; k--)
            acc[k] = ~vld_pipe[k] | acc[k+1];
    end

    assign in_ready_o = ~clear_i & ((STAGES == 0) ? out_ready_i : acc[1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            st_g_q     <= '0;
            st_p_q     <= '0;
        end else if (clear_i) begin
            vld_pipe <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (acc[k]) begin
                    vld_pipe[k]   <= nxt_vld[k];
                    first_pipe[k] <= nxt_first[k];
                    st_g_q[k]     <= nxt_g[k];
                    st_p_q[k]     <= nxt_p[k];
                end
            end
        end
    end

    // Chain fixup: fold the previous beat's group carry into this beat.
    assign cin         = res_first ? 1'b0 : chain_g_q;
    assign pin         = res_first ? 1'b1 : chain_p_q;
    assign go_o        = res_g | (res_p & {WIDTH{cin}});
    assign po_o        = res_p & {WIDTH{pin}};
    // A flush cycle never completes an output transfer.
    assign out_valid_o = res_vld & ~clear_i;
    assign fire        = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_g_q <= 1'b0;
            chain_p_q <= 1'b1;
        end else if (clear_i) begin
            chain_g_q <= 1'b0;
            chain_p_q <= 1'b1;
        end else if (fire) begin
            chain_g_q <= go_o[WIDTH-1];
            chain_p_q <= po_o[WIDTH-1];
        end
    end

endmodule
